// File: rtl/sdram_pkg.sv
// Shared SDRAM/Wishbone definitions: address field layout, tester FSM states, test pattern.
// No logic of its own; imported by the tester, its bus interface and the controller.
package sdram_pkg;

    localparam int SDRAM_ADDR_W = 23;
    localparam int SDRAM_DATA_W = 32;

    // Word address layout {BA[1:0], row[10:0], col[9:0]}
    localparam int BA_HI  = 22;
    localparam int BA_LO  = 21;
    localparam int ROW_HI = 20;
    localparam int ROW_LO = 10;
    localparam int COL_HI = 9;
    localparam int COL_LO = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_GAP,
        ST_RD_REQ,
        ST_RD_GAP,
        ST_FINISH
    } tester_state_t;

    function automatic logic [SDRAM_DATA_W-1:0] pat(input logic [SDRAM_ADDR_W-1:0] a,
                                                    input logic [SDRAM_DATA_W-1:0] seed);
        return SDRAM_DATA_W'(a) ^ seed;
    endfunction

endpackage

// File: rtl/wb_mem_tester_if.sv
// Wishbone initiator/target bundle between the memory tester and the SDRAM controller slave port.
// Pure wiring; ack is a level from the target and may stay high for several cycles.
interface wb_mem_tester_if import sdram_pkg::*; #(
    parameter int ADDR_W = SDRAM_ADDR_W,
    parameter int DATA_W = SDRAM_DATA_W
);
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dat_w;
    logic [DATA_W-1:0] dat_r;
    logic              we;
    logic              stb;
    logic              cyc;
    logic              ack;

    modport master (output adr, dat_w, we, stb, cyc, input dat_r, ack);
    modport slave  (input adr, dat_w, we, stb, cyc, output dat_r, ack);
endinterface

// File: rtl/wb_tester_checker.sv
// Read-back comparator: saturating mismatch counter plus capture of the first failing address.
// Results register one cycle after chk_en; never stalls, clr wins over a same-cycle compare.
module wb_tester_checker #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              chk_en,
    input  logic [DATA_W-1:0] exp,
    input  logic [DATA_W-1:0] act,
    input  logic [ADDR_W-1:0] addr,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            err_count      <= '0;
            first_err_addr <= '0;
        end else if (chk_en && (exp != act)) begin
            if (err_count != '1) begin
                err_count <= err_count + CNT_W'(1);
            end
            if (err_count == '0) begin
                first_err_addr <= addr;
            end
        end
    end

endmodule

// File: rtl/wb_mem_tester.sv
// Writes pat(addr) over NUM_WORDS words, reads them back and checks; one bus transaction at a time.
// Holds stb until ack or TIMEOUT stb cycles; waits for ack to drop before the next request.
module wb_mem_tester import sdram_pkg::*; #(
    parameter int                ADDR_W     = SDRAM_ADDR_W,
    parameter int                DATA_W     = SDRAM_DATA_W,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter int                NUM_WORDS  = 1024,
    parameter logic [DATA_W-1:0] SEED       = 32'hA5A5_5A5A,
    parameter int                TIMEOUT    = 4095
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    wb_mem_tester_if.master   wb,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam int                TO_W     = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);

    tester_state_t     state;
    logic [ADDR_W-1:0] idx;
    logic [TO_W-1:0]   to_cnt;
    logic [ADDR_W-1:0] nxt_adr;
    logic              to_hit;
    logic              chk_en;
    logic              clr;

    function automatic logic [DATA_W-1:0] pat_w(input logic [ADDR_W-1:0] a);
        return DATA_W'(pat(SDRAM_ADDR_W'(a), SDRAM_DATA_W'(SEED)));
    endfunction

    // Address wraps modulo 2^ADDR_W through plain truncation
    assign nxt_adr = START_ADDR + idx + ADDR_W'(1);
    assign to_hit  = (to_cnt == TO_W'(TIMEOUT - 1));
    assign chk_en  = (state == ST_RD_REQ) && wb.ack;
    assign clr     = (state == ST_IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            idx      <= '0;
            to_cnt   <= '0;
            wb.adr   <= '0;
            wb.dat_w <= '0;
            wb.we    <= 1'b0;
            wb.stb   <= 1'b0;
            wb.cyc   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                        timeout  <= 1'b0;
                        idx      <= '0;
                        to_cnt   <= '0;
                        wb.adr   <= START_ADDR;
                        wb.dat_w <= pat_w(START_ADDR);
                        wb.we    <= 1'b1;
                        wb.stb   <= 1'b1;
                        wb.cyc   <= 1'b1;
                        state    <= ST_WR_REQ;
                    end
                end
                ST_WR_REQ, ST_RD_REQ: begin
                    to_cnt <= to_cnt + TO_W'(1);
                    if (wb.ack) begin
                        wb.stb <= 1'b0;
                        wb.cyc <= 1'b0;
                        state  <= (state == ST_WR_REQ) ? ST_WR_GAP : ST_RD_GAP;
                    end else if (to_hit) begin
                        wb.stb  <= 1'b0;
                        wb.cyc  <= 1'b0;
                        timeout <= 1'b1;
                        state   <= ST_FINISH;
                    end
                end
                ST_WR_GAP: begin
                    if (!wb.ack) begin
                        wb.stb <= 1'b1;
                        wb.cyc <= 1'b1;
                        to_cnt <= '0;
                        if (idx == LAST_IDX) begin
                            idx      <= '0;
                            wb.adr   <= START_ADDR;
                            wb.dat_w <= pat_w(START_ADDR);
                            wb.we    <= 1'b0;
                            state    <= ST_RD_REQ;
                        end else begin
                            idx      <= idx + ADDR_W'(1);
                            wb.adr   <= nxt_adr;
                            wb.dat_w <= pat_w(nxt_adr);
                            state    <= ST_WR_REQ;
                        end
                    end
                end
                ST_RD_GAP: begin
                    if (!wb.ack) begin
                        if (idx == LAST_IDX) begin
                            state <= ST_FINISH;
                        end else begin
                            idx      <= idx + ADDR_W'(1);
                            wb.adr   <= nxt_adr;
                            wb.dat_w <= pat_w(nxt_adr);
                            wb.stb   <= 1'b1;
                            wb.cyc   <= 1'b1;
                            to_cnt   <= '0;
                            state    <= ST_RD_REQ;
                        end
                    end
                end
                ST_FINISH: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (err_count == '0) && !timeout;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    wb_tester_checker #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CNT_W  (16)
    ) u_checker (
        .clk            (clk),
        .rst            (rst),
        .clr            (clr),
        .chk_en         (chk_en),
        .exp            (pat_w(wb.adr)),
        .act            (wb.dat_r),
        .addr           (wb.adr),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

endmodule

// File: tb/tb_wb_mem_tester.sv
// Directed bench: 16-word tester against a 3-cycle-latency responder, a wrap-around tester
// against a 1-cycle responder, and a narrow checker instance for counter saturation.
module tb_wb_mem_tester;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0, start1 = 1'b0;
    logic mon_clr0 = 1'b0, mon_clr1 = 1'b0;
    logic corrupt = 1'b0, nowr3 = 1'b0;
    int   n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    wb_mem_tester_if b0 ();
    wb_mem_tester_if b1 ();

    logic        busy0, done0, pass0, to0;
    logic [15:0] ec0;
    logic [22:0] fe0;
    logic        busy1, done1, pass1, to1;
    logic [15:0] ec1;
    logic [22:0] fe1;

    wb_mem_tester #(.NUM_WORDS(16)) u0 (
        .clk(clk), .rst(rst), .start(start0), .wb(b0),
        .busy(busy0), .done(done0), .pass(pass0), .timeout(to0),
        .err_count(ec0), .first_err_addr(fe0)
    );

    wb_mem_tester #(.START_ADDR(23'h7FFFFE), .NUM_WORDS(4)) u1 (
        .clk(clk), .rst(rst), .start(start1), .wb(b1),
        .busy(busy1), .done(done1), .pass(pass1), .timeout(to1),
        .err_count(ec1), .first_err_addr(fe1)
    );

    logic        c_clr = 1'b0, c_en = 1'b0;
    logic [31:0] c_exp = '0, c_act = '0;
    logic [22:0] c_addr = '0;
    logic [3:0]  c_ec;
    logic [22:0] c_fe;

    wb_tester_checker #(.ADDR_W(23), .DATA_W(32), .CNT_W(4)) u_chk (
        .clk(clk), .rst(rst), .clr(c_clr), .chk_en(c_en), .exp(c_exp), .act(c_act),
        .addr(c_addr), .err_count(c_ec), .first_err_addr(c_fe)
    );

    // Responder 0: ack three edges after stb, held two cycles, perfect 16-word memory
    logic [31:0] mem0 [0:15];
    int          w0 = 0, h0 = 0, wr_n0 = 0;
    always @(posedge clk) begin
        if (rst) begin
            b0.ack <= 1'b0;
            w0     <= 0;
            h0     <= 0;
        end else begin
            if (mon_clr0) wr_n0 <= 0;
            if (h0 != 0) begin
                h0 <= h0 - 1;
                if (h0 == 1) b0.ack <= 1'b0;
            end else if (b0.stb && !(nowr3 && b0.we && wr_n0 == 2)) begin
                if (w0 == 2) begin
                    b0.ack <= 1'b1;
                    h0     <= 2;
                    w0     <= 0;
                    if (b0.we) begin
                        mem0[b0.adr[3:0]] <= b0.dat_w;
                        wr_n0             <= wr_n0 + 1;
                    end else begin
                        b0.dat_r <= mem0[b0.adr[3:0]] ^
                                    {31'd0, corrupt && (b0.adr == 23'd5 || b0.adr == 23'd9)};
                    end
                end else begin
                    w0 <= w0 + 1;
                end
            end else begin
                w0 <= 0;
            end
        end
    end

    // Bus monitor 0: transaction counts, protocol and write-data checks, stb run length
    int          wr0 = 0, rd0 = 0, perr0 = 0, derr0 = 0, run0 = 0, lastrun0 = 0;
    logic        p_stb0 = 1'b0, p_acc0 = 1'b0, p_we0 = 1'b0;
    logic [22:0] p_adr0 = '0;
    logic [31:0] p_dat0 = '0;
    always @(negedge clk) begin
        if (mon_clr0) begin
            wr0 <= 0; rd0 <= 0; perr0 <= 0; derr0 <= 0; run0 <= 0; lastrun0 <= 0;
        end else begin
            if (b0.stb) run0 <= run0 + 1;
            else if (run0 != 0) begin
                lastrun0 <= run0;
                run0     <= 0;
            end
            if (b0.cyc != b0.stb) perr0 <= perr0 + 1;
            else if (p_stb0 && b0.stb &&
                     (p_acc0 || b0.adr != p_adr0 || b0.we != p_we0 || b0.dat_w != p_dat0))
                perr0 <= perr0 + 1;
            if (b0.stb && b0.ack) begin
                if (b0.we) begin
                    wr0 <= wr0 + 1;
                    if (b0.dat_w != ({9'd0, b0.adr} ^ 32'hA5A5_5A5A)) derr0 <= derr0 + 1;
                end else begin
                    rd0 <= rd0 + 1;
                end
            end
        end
        p_stb0 <= b0.stb;
        p_acc0 <= b0.stb && b0.ack;
        p_adr0 <= b0.adr;
        p_we0  <= b0.we;
        p_dat0 <= b0.dat_w;
    end

    // Responder 1: one-cycle ack pulse; test addresses differ in their low two bits
    logic [31:0] mem1 [0:3];
    always @(posedge clk) begin
        if (rst) begin
            b1.ack <= 1'b0;
        end else begin
            b1.ack <= b1.stb && !b1.ack;
            if (b1.stb && !b1.ack) begin
                if (b1.we) mem1[b1.adr[1:0]] <= b1.dat_w;
                else       b1.dat_r <= mem1[b1.adr[1:0]];
            end
        end
    end

    logic [22:0] adrq1 [$];
    logic [31:0] datq1 [$];
    always @(negedge clk) begin
        if (mon_clr1) begin
            adrq1.delete();
            datq1.delete();
        end else if (b1.stb && b1.ack && b1.we) begin
            adrq1.push_back(b1.adr);
            datq1.push_back(b1.dat_w);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_test(input int which);
        if (which == 0) begin start0 = 1'b1; mon_clr0 = 1'b1; end
        else            begin start1 = 1'b1; mon_clr1 = 1'b1; end
        tick();
        start0 = 1'b0; start1 = 1'b0; mon_clr0 = 1'b0; mon_clr1 = 1'b0;
    endtask

    task automatic wait_done(input int which, input int budget, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if ((which == 0) ? done0 : done1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) chk(tag, 64'd0, 64'd1);
    endtask

    logic [22:0] exp_adr [4] = '{23'h7FFFFE, 23'h7FFFFF, 23'h000000, 23'h000001};
    logic [31:0] exp_dat [4] = '{32'hA5DAA5A4, 32'hA5DAA5A5, 32'hA5A55A5A, 32'hA5A55A5B};

    initial begin
        repeat (3) tick();
        chk("rst_flags", {busy0, done0, pass0, to0, b0.stb, b0.cyc, b0.we}, 0);
        chk("rst_err_count", ec0, 0);
        chk("rst_first_err", fe0, 0);
        chk("rst_adr_dat", {b0.adr, b0.dat_w}, 0);
        rst = 1'b0;
        tick();

        // Clean 16-word pass
        start_test(0);
        wait_done(0, 2000, "clean_done_timeout");
        chk("clean_flags", {busy0, done0, pass0, to0}, 4'b0110);
        chk("clean_err_count", ec0, 0);
        chk("clean_writes", wr0, 16);
        chk("clean_reads", rd0, 16);
        chk("clean_protocol", perr0, 0);
        chk("clean_wr_data", derr0, 0);

        // Corrupted reads at 5 and 9, with an extra start while busy
        corrupt = 1'b1;
        start_test(0);
        repeat (20) tick();
        chk("busy_mid_test", busy0, 1);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        wait_done(0, 2000, "corrupt_done_timeout");
        chk("corrupt_err_count", ec0, 2);
        chk("corrupt_first_err", fe0, 5);
        chk("corrupt_flags", {busy0, done0, pass0, to0}, 4'b0100);
        chk("restart_ignored_wr", wr0, 16);
        chk("restart_ignored_rd", rd0, 16);
        corrupt = 1'b0;

        // Third write never acknowledged
        nowr3 = 1'b1;
        start_test(0);
        wait_done(0, 6000, "timeout_done_timeout");
        chk("timeout_flags", {busy0, done0, pass0, to0}, 4'b0101);
        chk("timeout_stb_cycles", lastrun0, 4095);
        chk("timeout_acked_writes", wr0, 2);
        chk("timeout_protocol", perr0, 0);
        nowr3 = 1'b0;

        // Reset during read #2 while stb is high
        start_test(0);
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 1000; i++) begin
                if (rd0 >= 1 && b0.stb && !b0.we) begin
                    hit = 1'b1;
                    break;
                end
                tick();
            end
            chk("rd2_reached", hit, 1);
        end
        rst = 1'b1;
        tick();
        chk("midrst_flags", {busy0, done0, pass0, to0, b0.stb, b0.cyc, b0.we}, 0);
        chk("midrst_err_adr", {ec0, fe0, b0.adr}, 0);
        rst = 1'b0;
        tick();
        start_test(0);
        wait_done(0, 2000, "after_rst_done_timeout");
        chk("after_rst_flags", {busy0, done0, pass0, to0}, 4'b0110);
        chk("after_rst_reads", rd0, 16);

        // Address wrap at the top of the space
        start_test(1);
        wait_done(1, 500, "wrap_done_timeout");
        chk("wrap_flags", {busy1, done1, pass1, to1}, 4'b0110);
        chk("wrap_nwrites", adrq1.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wrap_adr%0d", i), (adrq1.size() > i) ? adrq1[i] : 23'h0, exp_adr[i]);
            chk($sformatf("wrap_dat%0d", i), (datq1.size() > i) ? datq1[i] : 32'h0, exp_dat[i]);
        end

        // Checker saturation on a 4-bit counter
        c_clr = 1'b1;
        tick();
        c_clr = 1'b0;
        c_en = 1'b1; c_exp = 32'h1234; c_act = 32'h1234; c_addr = 23'd1;
        repeat (2) tick();
        chk("chk_match_no_err", c_ec, 0);
        c_en = 1'b0; c_act = 32'h1235;
        tick();
        chk("chk_disabled_no_err", c_ec, 0);
        for (int i = 0; i < 20; i++) begin
            c_en = 1'b1; c_addr = 23'(3 + i);
            tick();
            if (i == 0) chk("chk_first_cnt", {c_ec, c_fe}, {4'd1, 23'd3});
        end
        c_en = 1'b0;
        chk("chk_saturated", c_ec, 4'hF);
        chk("chk_first_kept", c_fe, 3);
        c_clr = 1'b1;
        tick();
        c_clr = 1'b0;
        chk("chk_clear", {c_ec, c_fe}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
